// File: rtl/ip_src_arb.sv
// ip_src_arb: grants the IP-to-stream datapath to one of two sources for a whole packet (header + payload).
// Optional per-source completed-packet counters are enabled by defining IP_SRC_ARB_PKT_CNT_EN.

`ifndef IP_HDR_W
`define IP_HDR_W 160
`endif
`ifndef IP_HDR_BYTES
`define IP_HDR_BYTES 20
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module ip_src_arb (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         src0_arb_hdr_val,
  input  logic [`IP_HDR_W-1:0]         src0_arb_ip_hdr,
  output logic                         arb_src0_hdr_rdy,
  input  logic                         src0_arb_data_val,
  input  logic [`MAC_INTERFACE_W-1:0]  src0_arb_data,
  input  logic                         src0_arb_data_last,
  input  logic [`MAC_PADBYTES_W-1:0]   src0_arb_data_padbytes,
  output logic                         arb_src0_data_rdy,

  input  logic                         src1_arb_hdr_val,
  input  logic [`IP_HDR_W-1:0]         src1_arb_ip_hdr,
  output logic                         arb_src1_hdr_rdy,
  input  logic                         src1_arb_data_val,
  input  logic [`MAC_INTERFACE_W-1:0]  src1_arb_data,
  input  logic                         src1_arb_data_last,
  input  logic [`MAC_PADBYTES_W-1:0]   src1_arb_data_padbytes,
  output logic                         arb_src1_data_rdy,

  output logic                         arb_dst_hdr_val,
  output logic [`IP_HDR_W-1:0]         arb_dst_ip_hdr,
  input  logic                         dst_arb_hdr_rdy,
  output logic                         arb_dst_data_val,
  output logic [`MAC_INTERFACE_W-1:0]  arb_dst_data,
  output logic                         arb_dst_data_last,
  output logic [`MAC_PADBYTES_W-1:0]   arb_dst_data_padbytes,
`ifdef IP_SRC_ARB_PKT_CNT_EN
  output logic [31:0]                  arb_pkt_cnt_0,
  output logic [31:0]                  arb_pkt_cnt_1,
`endif
  input  logic                         dst_arb_data_rdy
);

  typedef struct packed {
    logic [3:0]               version;
    logic [3:0]               ihl;
    logic [7:0]               tos;
    logic [15:0]              tot_len;
    logic [`IP_HDR_W-33:0]    rest;
  } ip_pkt_hdr;

  localparam logic [1:0]  ST_IDLE      = 2'd0;
  localparam logic [1:0]  ST_HDR       = 2'd1;
  localparam logic [1:0]  ST_DATA      = 2'd2;
  localparam logic [15:0] HDR_ONLY_LEN = 16'(`IP_HDR_BYTES);

  // Per-source views of the two input bundles so the rest of the block is indexed by grant.
  logic [1:0]                   hdr_val_vec;
  logic [1:0]                   data_val_vec;
  logic [1:0]                   data_last_vec;
  logic [`IP_HDR_W-1:0]         ip_hdr_arr  [2];
  logic [`MAC_INTERFACE_W-1:0]  data_arr    [2];
  logic [`MAC_PADBYTES_W-1:0]   pad_arr     [2];

  assign hdr_val_vec   = {src1_arb_hdr_val, src0_arb_hdr_val};
  assign data_val_vec  = {src1_arb_data_val, src0_arb_data_val};
  assign data_last_vec = {src1_arb_data_last, src0_arb_data_last};
  assign ip_hdr_arr[0] = src0_arb_ip_hdr;
  assign ip_hdr_arr[1] = src1_arb_ip_hdr;
  assign data_arr[0]   = src0_arb_data;
  assign data_arr[1]   = src1_arb_data;
  assign pad_arr[0]    = src0_arb_data_padbytes;
  assign pad_arr[1]    = src1_arb_data_padbytes;

  logic [1:0]                   state_reg, state_next;
  logic                         grant_reg, grant_next;
  logic                         last_grant_reg, last_grant_next;
  logic                         arb_pick;

  ip_pkt_hdr                    sel_hdr;
  logic                         sel_hdr_val;
  logic                         sel_data_val;
  logic                         sel_data_last;
  logic [`MAC_INTERFACE_W-1:0]  sel_data;
  logic [`MAC_PADBYTES_W-1:0]   sel_pad;

  logic                         hdr_hs;
  logic                         data_hs;
  logic                         hdr_only;
  logic                         pkt_done;
  logic [1:0]                   grant_onehot;
  logic [1:0]                   hdr_rdy_vec;
  logic [1:0]                   data_rdy_vec;

  assign sel_hdr       = ip_pkt_hdr'(ip_hdr_arr[grant_reg]);
  assign sel_hdr_val   = hdr_val_vec[grant_reg];
  assign sel_data_val  = data_val_vec[grant_reg];
  assign sel_data_last = data_last_vec[grant_reg];
  assign sel_data      = data_arr[grant_reg];
  assign sel_pad       = pad_arr[grant_reg];

  assign hdr_hs   = (state_reg == ST_HDR)  && sel_hdr_val  && dst_arb_hdr_rdy;
  assign data_hs  = (state_reg == ST_DATA) && sel_data_val && dst_arb_data_rdy;
  assign hdr_only = (sel_hdr.tot_len == HDR_ONLY_LEN);
  assign pkt_done = (hdr_hs && hdr_only) || (data_hs && sel_data_last);

  // Round-robin: on a tie the source that did not win last time gets the destination.
  always_comb begin
    arb_pick = 1'b0;
    if (hdr_val_vec[0] && hdr_val_vec[1]) begin
      arb_pick = ~last_grant_reg;
    end else begin
      arb_pick = hdr_val_vec[1];
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|hdr_val_vec) begin
          grant_next      = arb_pick;
          last_grant_next = arb_pick;
          state_next      = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdr_hs) begin
          state_next = hdr_only ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_hs && sel_data_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Only the granted source ever sees a ready; the other is held off until the next IDLE.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
    assign grant_onehot[gi] = (grant_reg == 1'(gi));
    assign hdr_rdy_vec[gi]  = (state_reg == ST_HDR)  && grant_onehot[gi] && dst_arb_hdr_rdy;
    assign data_rdy_vec[gi] = (state_reg == ST_DATA) && grant_onehot[gi] && dst_arb_data_rdy;
  end

  assign arb_src0_hdr_rdy  = hdr_rdy_vec[0];
  assign arb_src1_hdr_rdy  = hdr_rdy_vec[1];
  assign arb_src0_data_rdy = data_rdy_vec[0];
  assign arb_src1_data_rdy = data_rdy_vec[1];

  always_comb begin
    arb_dst_hdr_val       = 1'b0;
    arb_dst_ip_hdr        = '0;
    arb_dst_data_val      = 1'b0;
    arb_dst_data          = '0;
    arb_dst_data_last     = 1'b0;
    arb_dst_data_padbytes = '0;
    if (state_reg == ST_HDR) begin
      arb_dst_hdr_val = sel_hdr_val;
      arb_dst_ip_hdr  = sel_hdr;
    end
    if (state_reg == ST_DATA) begin
      arb_dst_data_val      = sel_data_val;
      arb_dst_data          = sel_data;
      arb_dst_data_last     = sel_data_last;
      arb_dst_data_padbytes = sel_pad;
    end
  end

`ifdef IP_SRC_ARB_PKT_CNT_EN
  // A packet counts on the handshake that returns to IDLE; plain 32-bit wrap.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pkt_cnt
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (pkt_done && grant_onehot[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end
  assign arb_pkt_cnt_0 = g_pkt_cnt[0].cnt_reg;
  assign arb_pkt_cnt_1 = g_pkt_cnt[1].cnt_reg;
`endif

endmodule
